// File: rtl/jenc_pkg.sv
// -----------------------------------------------------------------------------
// jenc_pkg
// Shared definitions for the JPEG encoder engine blocks.
//   - jenc_state_e : byte serializer FSM states
//   - EOI marker bytes (FF D9) appended after the last payload byte
//   - JENC_SIZE_W  : default width of frame size / byte count fields
// -----------------------------------------------------------------------------
package jenc_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_EOI_FF = 2'd2,
    ST_EOI_D9 = 2'd3
  } jenc_state_e;

  localparam logic [7:0] EOI_MARK_HI = 8'hFF;
  localparam logic [7:0] EOI_MARK_LO = 8'hD9;

  localparam int JENC_SIZE_W = 20;

endpackage : jenc_pkg

// File: rtl/jenc_byte_serializer.sv
// -----------------------------------------------------------------------------
// jenc_byte_serializer
// Converts 32-bit packed encoder words into a big-endian byte stream.
// Padding bytes of the final word are trimmed using the frame byte size, an
// optional EOI marker (FF D9) is appended, and transferred bytes are counted
// per frame.
//
// Build option:
//   JENC_EOI_APPEND_EN  defined -> FF D9 follows the last payload byte, tlast
//                                  sits on D9, byte_cnt includes the marker.
//                       undefined -> tlast sits on the last payload byte.
//
// Ports:
//   clk         system clock, rising edge
//   resetn      synchronous active-low reset
//   in_data     encoder word, byte 0 = in_data[31:24] goes out first
//   in_tlast    final word of the frame
//   in_valid    word present
//   in_hold     backpressure to encoder (accept = in_valid & ~in_hold)
//   in_size     frame payload bytes, only looked at with the tlast word
//   out_data    output byte
//   out_tlast   final byte of the frame
//   out_valid   byte present
//   out_hold    consumer backpressure (transfer = out_valid & ~out_hold)
//   byte_cnt    bytes transferred in the current / last frame (saturating)
//   frame_done  one-cycle pulse after the out_tlast byte transfers
// -----------------------------------------------------------------------------
module jenc_byte_serializer
  import jenc_pkg::*;
#(
  parameter int SIZE_W = JENC_SIZE_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       in_data,
  input  logic              in_tlast,
  input  logic              in_valid,
  output logic              in_hold,
  input  logic [SIZE_W-1:0] in_size,
  output logic [7:0]        out_data,
  output logic              out_tlast,
  output logic              out_valid,
  input  logic              out_hold,
  output logic [SIZE_W-1:0] byte_cnt,
  output logic              frame_done
);

  jenc_state_e       state_reg, state_next;
  logic [31:0]       word_reg, word_next;
  logic [1:0]        idx_reg, idx_next;
  logic [2:0]        nb_reg, nb_next;
  logic              last_reg, last_next;
  logic [SIZE_W-1:0] cnt_reg;
  logic              restart_reg;
  logic              frame_done_reg;

  logic              xfer;
  logic              at_final;
  logic              exhaust;
  logic              accept;
  logic [2:0]        accept_nb;
  logic [7:0]        cur_byte;

  // Only the two low bits of the size decide how many bytes of the tlast
  // word carry payload; the rest of the field is informational here.
  logic              unused_size_hi;
  assign unused_size_hi = ^in_size[SIZE_W-1:2];

  assign out_valid = (state_reg != ST_EMPTY);
  assign xfer      = out_valid & ~out_hold;
  assign at_final  = ({1'b0, idx_reg} == (nb_reg - 3'd1));
  assign exhaust   = (state_reg == ST_SHIFT) & xfer & at_final;

  // Opening the input on the exhausting cycle of a non-last word lets the
  // next word land without a bubble; this is combinational from out_hold.
  assign in_hold   = (state_reg != ST_EMPTY) & ~(exhaust & ~last_reg);
  assign accept    = in_valid & ~in_hold;

  // A size that is a multiple of 4 means the final word is full.
  assign accept_nb = (in_tlast && (in_size[1:0] != 2'd0)) ? {1'b0, in_size[1:0]} : 3'd4;

  always_comb begin
    cur_byte = word_reg[31:24];
    case (idx_reg)
      2'd0:    cur_byte = word_reg[31:24];
      2'd1:    cur_byte = word_reg[23:16];
      2'd2:    cur_byte = word_reg[15:8];
      default: cur_byte = word_reg[7:0];
    endcase
  end

  // Output byte mux
  always_comb begin
    out_data  = 8'h00;
    out_tlast = 1'b0;
    case (state_reg)
      ST_SHIFT: begin
        out_data = cur_byte;
`ifndef JENC_EOI_APPEND_EN
        out_tlast = last_reg & at_final;
`endif
      end
`ifdef JENC_EOI_APPEND_EN
      ST_EOI_FF: out_data = EOI_MARK_HI;
      ST_EOI_D9: begin
        out_data  = EOI_MARK_LO;
        out_tlast = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    idx_next   = idx_reg;
    nb_next    = nb_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          word_next  = in_data;
          idx_next   = 2'd0;
          nb_next    = accept_nb;
          last_next  = in_tlast;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (at_final) begin
            if (last_reg) begin
`ifdef JENC_EOI_APPEND_EN
              state_next = ST_EOI_FF;
`else
              state_next = ST_EMPTY;
`endif
            end else if (accept) begin
              word_next  = in_data;
              idx_next   = 2'd0;
              nb_next    = accept_nb;
              last_next  = in_tlast;
              state_next = ST_SHIFT;
            end else begin
              state_next = ST_EMPTY;
            end
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
`ifdef JENC_EOI_APPEND_EN
      ST_EOI_FF: if (xfer) state_next = ST_EOI_D9;
      ST_EOI_D9: if (xfer) state_next = ST_EMPTY;
`endif
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ST_EMPTY;
      word_reg       <= '0;
      idx_reg        <= '0;
      nb_reg         <= '0;
      last_reg       <= 1'b0;
      cnt_reg        <= '0;
      restart_reg    <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_reg       <= word_next;
      idx_reg        <= idx_next;
      nb_reg         <= nb_next;
      last_reg       <= last_next;
      frame_done_reg <= xfer & out_tlast;
      if (xfer) begin
        // The first byte after a finished frame (or reset) restarts the count.
        restart_reg <= out_tlast;
        if (restart_reg) begin
          cnt_reg <= SIZE_W'(1);
        end else if (cnt_reg != {SIZE_W{1'b1}}) begin
          cnt_reg <= cnt_reg + SIZE_W'(1);
        end
      end
    end
  end

  assign byte_cnt   = cnt_reg;
  assign frame_done = frame_done_reg;

endmodule : jenc_byte_serializer

// File: doc/jenc_byte_serializer.md
# jenc_byte_serializer

Downstream stage of the JPEG encoder engine. Accepts the encoder's 32-bit packed output words with a last-word flag and the frame byte size, and emits a big-endian byte stream for the readout interface. Trims padding bytes from the final word, optionally appends the EOI marker, and counts emitted bytes per frame.

## Interface
Parameters:
- SIZE_W, 20, width of size and byte-count fields.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low. One clock (clk); reset is synchronous and active-low.
- in_data  in  32  encoder word; byte 0 = in_data[31:24], first on the wire.
- in_tlast  in  1  final word of frame.
- in_valid  in  1  word present.
- in_hold  out  1  backpressure to encoder; word accepted when in_valid & ~in_hold.
- in_size  in  SIZE_W  total frame payload bytes; sampled only with the tlast word.
- out_data  out  8  output byte.
- out_tlast  out  1  final byte of frame, including EOI when enabled.
- out_valid  out  1  byte present.
- out_hold  in  1  consumer backpressure; byte transferred when out_valid & ~out_hold.
- byte_cnt  out  SIZE_W  bytes transferred in current/last frame.
- frame_done  out  1  one-cycle pulse after the out_tlast byte transfers.

## Operation
- Holding register: one 32-bit word, byte index idx[1:0], byte limit nb[2:0], last flag.
- On accept: nb = 4 for non-last words; for the tlast word nb = in_size[1:0]==0 ? 4 : in_size[1:0]. idx = 0.
- out_data = word byte idx; idx advances on each transfer. The word is exhausted when a transfer happens with idx == nb-1.
- FSM states: EMPTY, SHIFT, EOI_FF, EOI_D9.
  - EMPTY: out_valid=0. Accept word -> SHIFT.
  - SHIFT: out_valid=1. On exhaustion of a non-last word -> accept the next word in the same cycle if in_valid, else EMPTY. On exhaustion of the last word -> EOI_FF with the macro, else EMPTY.
  - EOI_FF: out_data=8'hFF. On transfer -> EOI_D9.
  - EOI_D9: out_data=8'hD9, out_tlast=1. On transfer -> EMPTY.
- in_hold = (state != EMPTY) & ~(state==SHIFT & exhausting non-last word this cycle). This path is combinational from out_hold and gives zero-bubble back-to-back words.
- byte_cnt increments on every byte transfer. It is reset to 1 on the first transfer after frame_done or after reset. It saturates at all ones, with no wrap.
- frame_done is registered and asserts the cycle after the out_tlast transfer.

## Timing
- Reset: out_valid=0, out_tlast=0, out_data=0, in_hold=0, byte_cnt=0, frame_done=0, state EMPTY. Reset mid-word discards the word without emitting the remainder.
- Latency: first byte out_valid 1 cycle after word accept.
- Throughput: 1 byte/cycle sustained. A 4-byte word occupies exactly 4 cycles with out_hold=0.
- out_data, out_tlast and out_valid hold stable while out_valid & out_hold.
- Simultaneous exhaustion and new-word accept: the new word's byte 0 appears the next cycle, with no gap.
- in_valid & in_tlast with in_size==0: treated as nb=4.

## Configuration
- JENC_EOI_APPEND_EN defined: the FF D9 marker follows the last payload byte. out_tlast sits on D9. byte_cnt includes the 2 marker bytes.
- Not defined: EOI states are absent. out_tlast sits on the last payload byte and byte_cnt equals the payload count.

## Structure
- Shared jenc package: FSM state enum, the EOI byte constants (8'hFF, 8'hD9), and the SIZE_W default.
- Single module, no sub-module. The byte mux and FSM fit in one file.

## Test plan
- Single frame, three words 0x11223344, 0x55667788, 0xAABBCCDD (tlast), in_size=10, macro off -> bytes 11 22 33 44 55 66 77 88 AA BB with tlast on BB. byte_cnt=10, frame_done pulses once.
- Same frame with JENC_EOI_APPEND_EN -> ... AA BB FF D9 with tlast on D9. byte_cnt=12.
- in_size=12, tlast word 0xDEADBEEF -> all 4 bytes emitted, no trimming.
- Continuous in_valid, out_hold=0 over 8 words -> 32 consecutive out_valid cycles. in_hold is low exactly on each word's 4th byte cycle.
- Random out_hold at 50% -> byte sequence identical to the no-hold run. Output stays stable during hold.
- Assert resetn=0 after byte 2 of a word -> all outputs reach reset values next cycle. The next frame starts cleanly with byte_cnt=1 after its first byte.
